ram_master: RTL and testbench

Bus-side initiator for the on-chip 1K x 16 block RAM: synchronous read, write-first, per-byte write enables, data out registered on the address edge. It takes PDP-11 style byte-addressed read/write requests from the CPU core through a REQ/ACK handshake. It drives the RAM word address, byte selects, write strobe and data, captures read data, and right-justifies byte reads. Odd-address word accesses and out-of-window addresses are rejected with an error completion, so the CPU can raise a bus-error trap.

---
 rtl/ram_master.sv | 170 +++++++++++++++++
 tb/tb_ram_master.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_master.sv
// Byte-addressed request/acknowledge initiator for a synchronous write-first block RAM.
// Rejects odd word accesses and out-of-window addresses with an error completion.
module ram_master #(
    parameter int          AW   = 10,
    parameter logic [15:0] BASE = 16'h0000
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          REQ,
    output logic          ACK,
    input  logic [15:0]   A,
    input  logic          WE,
    input  logic          BYTE,
    input  logic [15:0]   WD,
    output logic          RDY,
    output logic          ERR,
    output logic [15:0]   RD,
    output logic [AW-1:0] RADDR,
    output logic [1:0]    RSEL,
    output logic          RWR,
    output logic [15:0]   RDI,
    input  logic [15:0]   RDO
);

    localparam logic [16:0] WIN = 17'd1 << (AW + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_CAP  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_ack;
    logic            r_rdy;
    logic            r_err;
    logic [15:0]     r_rd;
    logic [AW-1:0]   r_raddr;
    logic [1:0]      r_rsel;
    logic            r_rwr;
    logic [15:0]     r_rdi;
    logic            r_we;
    logic            r_byte;
    logic            r_a0;
    logic            r_bad;

    logic [16:0]     w_ofs;
    logic            w_bad;
    logic [1:0]      w_rsel;
    logic [15:0]     w_rdi;
    logic [15:0]     w_rd_cap;

    assign ACK   = r_ack;
    assign RDY   = r_rdy;
    assign ERR   = r_err;
    assign RD    = r_rd;
    assign RADDR = r_raddr;
    assign RSEL  = r_rsel;
    assign RWR   = r_rwr;
    assign RDI   = r_rdi;

    // Window decode on the live request; 17-bit offset so A < BASE cannot alias into the window.
    always_comb begin
        w_ofs  = {1'b0, A} - {1'b0, BASE};
        w_bad  = (A < BASE) || (w_ofs >= WIN) || (!BYTE && A[0]);
        w_rsel = 2'b11;
        w_rdi  = WD;
        if (BYTE) begin
            w_rsel = A[0] ? 2'b10 : 2'b01;
            w_rdi  = {WD[7:0], WD[7:0]};
        end else begin
            w_rsel = 2'b11;
            w_rdi  = WD;
        end
    end

    // Right-justify and zero-extend byte reads from the RAM output word.
    always_comb begin
        w_rd_cap = RDO;
        if (r_byte) begin
            w_rd_cap = r_a0 ? {8'h00, RDO[15:8]} : {8'h00, RDO[7:0]};
        end else begin
            w_rd_cap = RDO;
        end
    end

    // Next-state decode for the accept / RAM access / capture sequence.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (REQ) begin
                    w_next = S_ACC;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_ACC:   w_next = S_CAP;
            S_CAP:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // RAM drive is registered at the accept edge so it is stable for the whole ACC cycle.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_ack   <= 1'b1;
            r_rdy   <= 1'b0;
            r_err   <= 1'b0;
            r_rd    <= 16'h0000;
            r_raddr <= '0;
            r_rsel  <= 2'b00;
            r_rwr   <= 1'b0;
            r_rdi   <= 16'h0000;
            r_we    <= 1'b0;
            r_byte  <= 1'b0;
            r_a0    <= 1'b0;
            r_bad   <= 1'b0;
        end else begin
            r_ack <= (w_next == S_IDLE);
            r_rdy <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (REQ) begin
                        r_we   <= WE;
                        r_byte <= BYTE;
                        r_a0   <= A[0];
                        r_bad  <= w_bad;
                        if (!w_bad) begin
                            r_raddr <= w_ofs[AW:1];
                            r_rsel  <= w_rsel;
                            r_rwr   <= WE;
                            r_rdi   <= w_rdi;
                        end else begin
                            r_rsel <= 2'b00;
                            r_rwr  <= 1'b0;
                        end
                    end
                end
                S_ACC: begin
                    r_rsel <= 2'b00;
                    r_rwr  <= 1'b0;
                end
                S_CAP: begin
                    r_rdy <= 1'b1;
                    r_err <= r_bad;
                    if (!r_bad && !r_we) begin
                        r_rd <= w_rd_cap;
                    end
                end
                default: begin
                    r_rsel <= 2'b00;
                    r_rwr  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_master.sv
// Self-checking bench for ram_master with a write-first 1K x 16 RAM model and a
// scoreboard of expected completions.
module tb_ram_master;
    localparam int AW = 10;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          REQ = 1'b0;
    logic          ACK;
    logic [15:0]   A = 16'h0000;
    logic          WE = 1'b0;
    logic          BYTE = 1'b0;
    logic [15:0]   WD = 16'h0000;
    logic          RDY;
    logic          ERR;
    logic [15:0]   RD;
    logic [AW-1:0] RADDR;
    logic [1:0]    RSEL;
    logic          RWR;
    logic [15:0]   RDI;
    logic [15:0]   RDO;
    logic          preload = 1'b1;

    typedef struct {
        logic        err;
        logic [15:0] rd;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] ram[0:1023];
    logic [15:0] ref_mem[0:1023];
    logic [15:0] last_rd = 16'h0000;
    int          n_chk = 0;
    int          n_pass = 0;

    ram_master #(.AW(AW), .BASE(16'h0000)) dut (
        .CLK(CLK), .nRST(nRST), .REQ(REQ), .ACK(ACK), .A(A), .WE(WE), .BYTE(BYTE),
        .WD(WD), .RDY(RDY), .ERR(ERR), .RD(RD), .RADDR(RADDR), .RSEL(RSEL),
        .RWR(RWR), .RDI(RDI), .RDO(RDO)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] init_word(input int i);
        logic [15:0] w;
        w = 16'(i);
        if (i == 0)      return 16'h15C0;
        else if (i == 1) return 16'h8000;
        else if (i == 2) return 16'h15C1;
        else             return {w[7:0] ^ 8'hA5, w[9:2]};
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                          input logic [1:0] sel, input logic wr);
        logic [15:0] m;
        m = old;
        if (wr && sel[0]) m[7:0] = d[7:0];
        if (wr && sel[1]) m[15:8] = d[15:8];
        return m;
    endfunction

    // RAM model: synchronous read, write-first, per-byte enables.
    always @(posedge CLK) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) ram[i] <= init_word(i);
        end else begin
            ram[RADDR] <= merge(ram[RADDR], RDI, RSEL, RWR);
            RDO        <= merge(ram[RADDR], RDI, RSEL, RWR);
        end
    end

    task automatic access(input logic [15:0] a, input logic we, input logic byt,
                          input logic [15:0] wd);
        logic        bad;
        int          wi;
        logic [1:0]  x_sel;
        logic [15:0] x_rdi;
        logic [15:0] v;
        exp_t        e;
        int          edges;
        bad   = (int'(a) >= 2048) || (!byt && a[0]);
        wi    = int'(a[10:1]);
        x_sel = bad ? 2'b00 : (byt ? (a[0] ? 2'b10 : 2'b01) : 2'b11);
        x_rdi = byt ? {wd[7:0], wd[7:0]} : wd;
        e.err = bad;
        if (!bad && we) begin
            ref_mem[wi] = merge(ref_mem[wi], x_rdi, x_sel, 1'b1);
        end else if (!bad) begin
            v = ref_mem[wi];
            last_rd = byt ? (a[0] ? {8'h00, v[15:8]} : {8'h00, v[7:0]}) : v;
        end
        e.rd = last_rd;
        REQ = 1'b1; A = a; WE = we; BYTE = byt; WD = wd;
        n_chk++; if (ACK !== 1'b1) $display("FAIL idle_ack a=%h: got %b want 1", a, ACK); else n_pass++;
        sb.push_back(e);
        @(posedge CLK); #1;
        REQ = 1'b0; A = ~a; WD = ~wd; WE = ~we; BYTE = ~byt;
        n_chk++; if (RSEL !== x_sel) $display("FAIL acc_rsel a=%h: got %b want %b", a, RSEL, x_sel); else n_pass++;
        n_chk++; if (RWR !== (we && !bad)) $display("FAIL acc_rwr a=%h: got %b want %b", a, RWR, we && !bad); else n_pass++;
        n_chk++; if (ACK !== 1'b0) $display("FAIL acc_ack a=%h: got %b want 0", a, ACK); else n_pass++;
        if (!bad) begin
            n_chk++; if (RADDR !== a[10:1]) $display("FAIL acc_raddr a=%h: got %h want %h", a, RADDR, a[10:1]); else n_pass++;
            n_chk++; if (RDI !== x_rdi) $display("FAIL acc_rdi a=%h: got %h want %h", a, RDI, x_rdi); else n_pass++;
        end
        @(posedge CLK); #1;
        n_chk++; if ({RSEL, RWR, RDY, ACK} !== 5'b00000) $display("FAIL cap_outputs a=%h: got rsel=%b rwr=%b rdy=%b ack=%b want all 0", a, RSEL, RWR, RDY, ACK); else n_pass++;
        edges = 1;
        while (RDY !== 1'b1 && edges < 6) begin
            @(posedge CLK); #1;
            edges++;
        end
        n_chk++; if (edges !== 2) $display("FAIL latency a=%h: got %0d want 2", a, edges); else n_pass++;
        n_chk++;
        if (RDY === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            if (ERR !== e.err || RD !== e.rd) $display("FAIL completion a=%h: got err=%b rd=%h want err=%b rd=%h", a, ERR, RD, e.err, e.rd);
            else n_pass++;
        end else begin
            $display("FAIL completion a=%h: no RDY within budget", a);
        end
        n_chk++; if (ACK !== 1'b1) $display("FAIL rdy_ack a=%h: got %b want 1", a, ACK); else n_pass++;
        @(posedge CLK); #1;
        n_chk++; if ({RDY, ERR} !== 2'b00) $display("FAIL rdy_pulse a=%h: got rdy=%b err=%b want 00", a, RDY, ERR); else n_pass++;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge CLK);
        #1;
        n_chk++; if ({ACK, RDY, ERR, RWR, RSEL} !== 6'b100000) $display("FAIL reset_ctrl: got ack=%b rdy=%b err=%b rwr=%b rsel=%b", ACK, RDY, ERR, RWR, RSEL); else n_pass++;
        n_chk++; if ({RD, RDI, RADDR} !== {16'h0000, 16'h0000, 10'h000}) $display("FAIL reset_data: got rd=%h rdi=%h raddr=%h want 0", RD, RDI, RADDR); else n_pass++;
        preload = 1'b0;
        nRST = 1'b1;
        @(posedge CLK); #1;
        n_chk++; if (ACK !== 1'b1 || RDY !== 1'b0) $display("FAIL post_reset: got ack=%b rdy=%b want 1 0", ACK, RDY); else n_pass++;
    endtask

    task automatic test_reads();
        access(16'h0000, 1'b0, 1'b0, 16'h0000);
        n_chk++; if (RD !== 16'h15C0) $display("FAIL word_read: got %h want 15c0", RD); else n_pass++;
        access(16'h0003, 1'b0, 1'b1, 16'h0000);
        n_chk++; if (RD !== 16'h0080) $display("FAIL byte_read_odd: got %h want 0080", RD); else n_pass++;
        access(16'h0002, 1'b0, 1'b1, 16'h0000);
        n_chk++; if (RD !== 16'h0000) $display("FAIL byte_read_even: got %h want 0000", RD); else n_pass++;
    endtask

    task automatic test_byte_write();
        access(16'h0005, 1'b1, 1'b1, 16'h12AB);
        access(16'h0004, 1'b0, 1'b0, 16'h0000);
        n_chk++; if (RD !== 16'hABC1) $display("FAIL raw_same_word: got %h want abc1", RD); else n_pass++;
    endtask

    task automatic test_errors();
        access(16'h0007, 1'b1, 1'b0, 16'hBEEF);
        access(16'h07FE, 1'b0, 1'b0, 16'h0000);
        access(16'h07FF, 1'b0, 1'b1, 16'h0000);
        access(16'h0800, 1'b0, 1'b1, 16'h0000);
        access(16'hFFFF, 1'b1, 1'b1, 16'h5555);
        access(16'h0006, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic test_back_to_back();
        int   idx;
        int   last_acc;
        int   rdys;
        logic acc;
        exp_t e;
        idx = 0; last_acc = -1; rdys = 0;
        REQ = 1'b1; A = 16'h0000; WE = 1'b0; BYTE = 1'b0;
        for (int c = 0; c < 20; c++) begin
            acc = REQ && ACK;
            if (acc) begin
                e.err = 1'b0;
                e.rd = ref_mem[idx];
                last_rd = e.rd;
                sb.push_back(e);
            end
            @(posedge CLK); #1;
            if (acc) begin
                n_chk++; if (ACK !== 1'b0) $display("FAIL b2b_ack_low idx=%0d: got %b want 0", idx, ACK); else n_pass++;
                if (last_acc >= 0) begin
                    n_chk++; if (c - last_acc !== 3) $display("FAIL b2b_spacing idx=%0d: got %0d want 3", idx, c - last_acc); else n_pass++;
                end
                last_acc = c;
                idx++;
                if (idx < 4) A = 16'(idx * 2);
                else REQ = 1'b0;
            end
            if (RDY === 1'b1) begin
                rdys++;
                n_chk++;
                if (sb.size() == 0) begin
                    $display("FAIL b2b_extra_rdy: got RDY with empty scoreboard");
                end else begin
                    e = sb.pop_front();
                    if (ERR !== e.err || RD !== e.rd) $display("FAIL b2b_data: got err=%b rd=%h want err=%b rd=%h", ERR, RD, e.err, e.rd);
                    else n_pass++;
                end
            end
        end
        n_chk++; if (rdys !== 4 || idx !== 4 || sb.size() != 0) $display("FAIL b2b_count: got rdys=%0d accepts=%0d want 4 4", rdys, idx); else n_pass++;
    endtask

    task automatic test_reset_mid_write();
        int rdys;
        REQ = 1'b1; A = 16'h0002; WE = 1'b1; BYTE = 1'b0; WD = 16'hDEAD;
        @(posedge CLK); #1;
        REQ = 1'b0;
        n_chk++; if (RWR !== 1'b1) $display("FAIL rst_acc_rwr: got %b want 1", RWR); else n_pass++;
        nRST = 1'b0;
        #1;
        n_chk++; if ({RWR, RSEL, RDY, ACK} !== 5'b00001) $display("FAIL rst_async: got rwr=%b rsel=%b rdy=%b ack=%b", RWR, RSEL, RDY, ACK); else n_pass++;
        @(posedge CLK); #1;
        nRST = 1'b1;
        last_rd = 16'h0000;
        rdys = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge CLK); #1;
            if (RDY === 1'b1) rdys++;
        end
        n_chk++; if (rdys !== 0 || ACK !== 1'b1) $display("FAIL rst_stale: got rdys=%0d ack=%b want 0 1", rdys, ACK); else n_pass++;
        access(16'h0002, 1'b0, 1'b0, 16'h0000);
        n_chk++; if (RD !== 16'h8000) $display("FAIL rst_unmodified: got %h want 8000", RD); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        test_reset();
        test_reads();
        test_byte_write();
        test_errors();
        test_back_to_back();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
